// File: rtl/tmds_hdmi_encoder.sv
// Multi-channel TMDS/HDMI symbol encoder: video 8b/10b, control, guard bands, TERC4 islands.
// Latency: 3 pix_clk cycles for every mode (S1 input reg, S2 q_m reg, S3 output reg).
// Backpressure: none; one symbol per channel per cycle, no stalls, no handshake.
module tmds_hdmi_encoder #(
  parameter int NUM_CH = 3
) (
  input  logic                  pix_clk,
  input  logic                  rst_n,
  input  logic [2:0]            mode,
  input  logic [8*NUM_CH-1:0]   din,
  input  logic [2*NUM_CH-1:0]   ctrl,
  input  logic [4*NUM_CH-1:0]   aux,
  output logic [10*NUM_CH-1:0]  dout,
  output logic [2:0]            dout_mode
);

  // Period types; codes 5-7 fall through to the control encoding.
  localparam logic [2:0] MODE_CTRL      = 3'd0;
  localparam logic [2:0] MODE_VIDEO     = 3'd1;
  localparam logic [2:0] MODE_VIDEO_GB  = 3'd2;
  localparam logic [2:0] MODE_ISLAND    = 3'd3;
  localparam logic [2:0] MODE_ISLAND_GB = 3'd4;

  // Guard-band symbols: GB_A on channels 0/2 of each triple, GB_B on channel 1
  // (GB_B also fills the non-zero channels of the island guard band).
  localparam logic [9:0] GB_A = 10'b1011001100;
  localparam logic [9:0] GB_B = 10'b0100110011;

  // TERC4 nibble-to-symbol mapping for data islands.
  function automatic logic [9:0] terc4(input logic [3:0] nib);
    logic [9:0] s;
    case (nib)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  // Control-period symbol for {c1,c0}.
  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  // Population count of a byte (0..8).
  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'b000, v[i]};
    end
    return s;
  endfunction

  logic [2:0] s1_mode;
  logic [2:0] s2_mode;

  // Shared mode travels alongside the per-channel data through all three stages.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mode   <= MODE_CTRL;
      s2_mode   <= MODE_CTRL;
      dout_mode <= MODE_CTRL;
    end else begin
      s1_mode   <= mode;
      s2_mode   <= s1_mode;
      dout_mode <= s2_mode;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam int KM = k % 3;

    logic [7:0] s1_d;
    logic [3:0] s1_n1;
    logic [1:0] s1_ctrl;
    logic [3:0] s1_aux;

    logic       flag1;
    logic [8:0] qm;

    logic [8:0] s2_qm;
    logic [3:0] s2_n1q;
    logic [3:0] s2_n0q;
    logic [1:0] s2_ctrl;
    logic [3:0] s2_aux;

    logic [5:0] n1w;
    logic [5:0] n0w;
    logic [5:0] delta;
    logic [4:0] cnt;
    logic [4:0] cnt_nxt;
    logic [9:0] sym_nxt;
    logic [9:0] sym_q;

    // S1: capture the channel's inputs and pre-count the ones in the pixel byte.
    always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_d    <= 8'd0;
        s1_n1   <= 4'd0;
        s1_ctrl <= 2'b00;
        s1_aux  <= 4'd0;
      end else begin
        s1_d    <= din[8*k +: 8];
        s1_n1   <= ones8(din[8*k +: 8]);
        s1_ctrl <= ctrl[2*k +: 2];
        s1_aux  <= aux[4*k +: 4];
      end
    end

    // Transition minimisation: XOR or XNOR chain, chosen to reduce toggles.
    always_comb begin
      qm    = 9'd0;
      flag1 = (s1_n1 > 4'd4) || ((s1_n1 == 4'd4) && !s1_d[0]);
      qm[0] = s1_d[0];
      for (int i = 1; i < 8; i++) begin
        qm[i] = flag1 ? ~(qm[i-1] ^ s1_d[i]) : (qm[i-1] ^ s1_d[i]);
      end
      qm[8] = ~flag1;
    end

    // S2: register q_m with its ones/zeros counts so S3 only does DC balancing.
    always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_qm   <= 9'd0;
        s2_n1q  <= 4'd0;
        s2_n0q  <= 4'd8;
        s2_ctrl <= 2'b00;
        s2_aux  <= 4'd0;
      end else begin
        s2_qm   <= qm;
        s2_n1q  <= ones8(qm[7:0]);
        s2_n0q  <= 4'd8 - ones8(qm[7:0]);
        s2_ctrl <= s1_ctrl;
        s2_aux  <= s1_aux;
      end
    end

    assign n1w = {2'b00, s2_n1q};
    assign n0w = {2'b00, s2_n0q};

    // S3 symbol select; video applies DC balancing, all other periods clear disparity.
    always_comb begin
      sym_nxt = ctrl_sym(s2_ctrl);
      delta   = 6'd0;
      cnt_nxt = 5'd0;
      case (s2_mode)
        MODE_VIDEO: begin
          if ((cnt == 5'd0) || (s2_n1q == s2_n0q)) begin
            sym_nxt = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
            delta   = s2_qm[8] ? (n1w - n0w) : (n0w - n1w);
          end else if ((!cnt[4] && (s2_n1q > s2_n0q)) || (cnt[4] && (s2_n0q > s2_n1q))) begin
            // cnt is non-zero here, so a clear sign bit means strictly positive.
            sym_nxt = {1'b1, s2_qm[8], ~s2_qm[7:0]};
            delta   = {4'b0000, s2_qm[8], 1'b0} + n0w - n1w;
          end else begin
            sym_nxt = {1'b0, s2_qm[8], s2_qm[7:0]};
            delta   = n1w - n0w - {4'b0000, ~s2_qm[8], 1'b0};
          end
          // 5-bit wrap is intended: legal streams never leave -10..+10.
          cnt_nxt = cnt + delta[4:0];
        end
        MODE_VIDEO_GB: begin
          sym_nxt = (KM == 1) ? GB_B : GB_A;
        end
        MODE_ISLAND: begin
          sym_nxt = terc4(s2_aux);
        end
        MODE_ISLAND_GB: begin
          sym_nxt = (k == 0) ? terc4({2'b11, s2_ctrl}) : GB_B;
        end
        default: begin
          sym_nxt = ctrl_sym(s2_ctrl);
        end
      endcase
    end

    // S3: output symbol register and the running disparity it implies.
    always_ff @(posedge pix_clk or negedge rst_n) begin
      if (!rst_n) begin
        sym_q <= 10'd0;
        cnt   <= 5'd0;
      end else begin
        sym_q <= sym_nxt;
        cnt   <= cnt_nxt;
      end
    end

    assign dout[10*k +: 10] = sym_q;
  end

endmodule

// File: doc/tmds_hdmi_encoder.md
# tmds_hdmi_encoder

Multi-channel TMDS/HDMI symbol encoder; the parametrised successor to the single-channel DVI encoder. It converts per-channel 8-bit pixel data, 2-bit control and 4-bit auxiliary nibbles into 10-bit symbols. It adds the HDMI video guard band, TERC4 data-island encoding, the data-island guard band and a delayed mode tag. It sits between the video/packet scheduler and the per-lane 10:1 serialisers, in the pix_clk domain.

## Interface
- NUM_CH, 3: number of TMDS data channels; channel index k = 0..NUM_CH-1 selects guard-band values (k mod 3).
- pix_clk  in  1  pixel clock; all logic rising-edge.
- rst_n  in  1  reset: asynchronous, active-low.
- mode  in  3  period type, shared by all channels: 0 CTRL, 1 VIDEO, 2 VIDEO_GB, 3 ISLAND, 4 ISLAND_GB, 5-7 treated as CTRL.
- din  in  8*NUM_CH  pixel byte per channel; channel k at [8k+7:8k].
- ctrl  in  2*NUM_CH  {c1,c0} per channel at [2k+1:2k]; on channel 0 this is {vsync,hsync}.
- aux  in  4*NUM_CH  TERC4 nibble per channel at [4k+3:4k].
- dout  out  10*NUM_CH  encoded symbol per channel at [10k+9:10k].
- dout_mode  out  3  mode aligned with dout.

## Operation
- Three-stage pipeline per channel. S1 registers din, its ones-count n1d (0..8), ctrl, aux and mode. S2 computes q_m and registers q_m, n1q = ones(q_m[7:0]) and n0q = 8-n1q. S3 is the output register.
- S2 transition minimisation: flag1 = (n1d>4) | (n1d==4 & d[0]==0). q_m[0]=d[0]. q_m[i] = flag1 ? ~(q_m[i-1]^d[i]) : q_m[i-1]^d[i] for i=1..7. q_m[8] = ~flag1.
- Per-channel running disparity cnt is 5-bit two's complement, range -16..15; valid streams stay within -10..+10 and no saturation is performed.
- S3 in VIDEO:
  - If cnt==0 or n1q==n0q: dout = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m[8] ? n1q-n0q : n0q-n1q.
  - Else if (cnt>0 & n1q>n0q) or (cnt<0 & n0q>n1q): dout = {1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + n0q - n1q.
  - Else: dout = {0, q_m[8], q_m[7:0]}; cnt += n1q - n0q - 2*~q_m[8].
- S3 in every non-VIDEO mode sets cnt to 0 and drives dout as follows:
  - CTRL: {c1,c0} 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - VIDEO_GB: k mod 3 = 0 or 2 → 1011001100; k mod 3 = 1 → 0100110011.
  - ISLAND: TERC4(aux_k).
  - ISLAND_GB: channel 0 → TERC4({1,1,c1,c0}); all other channels → 0100110011.
- TERC4 table, nibble→symbol: 0 1010011100, 1 1001100011, 2 1011100100, 3 1011100010, 4 0101110001, 5 0100011110, 6 0110001110, 7 0100111100, 8 1011001100, 9 0100111001, A 0110011100, B 1011000110, C 1010001110, D 1001110001, E 0101100011, F 1011000011.
- Channels are fully independent apart from the shared mode.

## Timing
- Latency is exactly 3 cycles for every mode. The input sampled at edge N appears on dout/dout_mode after edge N+2, i.e. is stable during cycle N+3.
- Throughput is one symbol per channel per cycle, with no stalls and no handshake.
- Reset (async assert) clears dout=0, dout_mode=0, all cnt=0 and all pipeline registers (mode=CTRL, ctrl=0, data=0). After release, dout shows 1101010100 per channel until the first sampled input arrives 3 cycles later.
- Reset mid-stream discards all in-flight symbols; disparity restarts at 0.
- Mode changes take effect per symbol with no gaps. A VIDEO symbol immediately following a non-VIDEO symbol starts with cnt=0.
- Undefined modes 5-7 are encoded as CTRL, and dout_mode carries the raw value.

## Test plan
- Reset: hold rst_n=0 with random inputs → dout=0, dout_mode=0. Release with mode=CTRL, ctrl=0 → every channel reads 1101010100 at all subsequent cycles.
- Disparity sequence: mode=VIDEO, din=0x00 on channel 0 for 3 cycles after a CTRL period → dout = 0100000000, 1111111111, 0100000000. Internal cnt = -8, +2, -6.
- Polarity case: after a CTRL period, VIDEO din=0xFF → dout=1000000000, cnt=-8. A subsequent CTRL symbol returns cnt to 0.
- Guard bands, NUM_CH=3: VIDEO_GB → channels 0/1/2 = 1011001100 / 0100110011 / 1011001100. ISLAND_GB with ch0 ctrl=2'b01 → ch0=1001110001, ch1=ch2=0100110011.
- TERC4 sweep: mode=ISLAND, aux stepping 0..F on all channels → table values in order, each exactly 3 cycles later, with dout_mode=3.
- Random mixed-mode stream over 10k cycles against a reference model: all outputs match, latency is 3, and |cnt| ≤ 10 throughout.
